ts_monomial_sequencer: RTL and testbench
========================================

Name: ts_monomial_sequencer

Overview:
- Parametrised, time-shared successor to the single-share first-cycle monomial logic of the masked PRINCE S-box.
- Accepts one N_SHARES-way shared N_IN-bit S-box input and applies a composable refresh.
- Then, over N_SHARES cycles (one per input share), emits every monomial of degree 1..MAX_DEG of that share, each split into two subshares with fresh randomness.
- Sits between the state/key-add datapath and the cross-share combination stage; valid/ready on both sides.

Parameters:
- N_IN, 4, S-box input width (variables; MSB of a share is the first variable "x").
- MAX_DEG, 3, highest monomial degree produced; legal range 1..N_IN.
- N_SHARES, 2, number of input shares, processed one per cycle; minimum 2.
- M (localparam, derived), 14 at defaults, = sum over d=1..MAX_DEG of C(N_IN,d). Monomial count.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- in_valid  in  1  input share set valid.
- in_ready  out  1  block can accept a new input.
- in_shares  in  N_SHARES*N_IN  share s at bits [s*N_IN +: N_IN].
- rand_comp  in  (N_SHARES-1)*N_IN  composable refresh randomness, sampled on accept.
- rand_fresh  in  M  per-monomial output masks, sampled whenever rand_req=1.
- rand_req  out  1  rand_fresh consumed this cycle; the source must present new bits next cycle.
- out_valid  out  1  output subshares valid.
- out_ready  in  1  downstream accepts the output.
- out_idx  out  max(1,$clog2(N_SHARES))  index of the share whose monomials are presented.
- out_last  out  1  out_idx == N_SHARES-1.
- out_sub1  out  M  monomial j XOR mask j.
- out_sub2  out  M  mask j.

Behaviour:
- One clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all registers 0; out_valid=0, out_idx=0, out_last=0, out_sub1=0, out_sub2=0; state=IDLE.
- in_ready and rand_req are combinational. in_ready=1 in IDLE.
- Monomial order, bit j of the M-wide buses:
  - degree ascending, then lexicographic over variable index, variable 0 = share MSB.
  - Defaults: x,y,z,w,xy,xz,xw,yz,yw,zw,xyz,xyw,xzw,yzw at bits 0..13.
- Refresh:
  - Refreshed share s = in_share[s] ^ rand_comp slice s, for s < N_SHARES-1.
  - Last share = in_share ^ XOR of all rand_comp slices.
  - The XOR of all shares is unchanged.
- Accept = in_valid && in_ready. On accept:
  - refreshed shares are stored in share_q;
  - output regs are loaded with the share-0 monomials (using the combinational refreshed share 0) and rand_fresh;
  - out_valid=1, out_idx=0 next cycle;
  - rand_req=1 in the accept cycle. Latency is 1 cycle.
- States:
  - IDLE: waiting for accept.
  - RUN: presenting the current share.
- Output handshake = out_valid && out_ready:
  - If !out_last: load the monomials of share_q[out_idx+1] with rand_fresh, increment out_idx, rand_req=1.
  - If out_last: if in_valid, accept back-to-back (in_ready=1 in this cycle) and behave exactly as an accept from IDLE. Otherwise go to IDLE, out_valid=0, out_idx=0.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last).
- Backpressure: while out_valid && !out_ready, all outputs hold stable, rand_req=0, and no randomness is consumed.
- Throughput: one input per N_SHARES cycles with no stalls.
- No combinational path from any input share bit to out_sub1 or out_sub2; outputs are always registered.
- Masking: each monomial is XORed with its own rand_fresh bit before the register. Unmasked monomials never reach a register.
- Reset asserted mid-operation: immediate return to the reset values; the in-flight input is discarded with no partial output.
- rand_fresh is required to be fresh for every rand_req=1 cycle. The block does not check this.

Decomposition:
- Shared package ts_sbox_pkg:
  - constant function monomial_count(N_IN, MAX_DEG);
  - constant function monomial_mask(N_IN, MAX_DEG, j) returning the N_IN-bit variable-select mask of monomial j;
  - state enum {IDLE, RUN}.
- One natural combinational sub-module, ts_monomial_eval:
  - inputs: one N_IN-bit share, M bits of randomness;
  - outputs: M-bit sub1 and sub2;
  - built with a generate loop AND-reducing the bits selected by monomial_mask.

Test Plan:
- Defaults. in_shares={share1=4'h0, share0=4'hB}, rand_comp=0, rand_fresh=0.
  - Cycle after accept: out_idx=0, out_sub1=14'h126D, out_sub2=0.
  - Next: out_idx=1, out_last=1, out_sub1=0.
- Same input, rand_fresh=14'h3FFF → out_sub1=14'h2D92, out_sub2=14'h3FFF. rand_req pulses exactly 2 times per input.
- Refresh: in_shares={4'h0,4'hF}, rand_comp=4'hF, rand_fresh=0 → share 0 gives out_sub1=0, share 1 gives out_sub1=14'h3FFF.
- Backpressure: out_ready=0 for 5 cycles at out_idx=0 → outputs stable, rand_req=0, in_ready=0. Release → idx 1 the next cycle.
- Back-to-back: in_valid held with out_ready=1 → in_ready high only on out_last handshake cycles; out_valid continuous; idx sequence 0,1,0,1.
- rst_n low while out_idx=1 → outputs 0 immediately (asynchronous); in_ready=1 after release; the next input processes from idx 0.
- Also N_IN=5, MAX_DEG=2, N_SHARES=3 (M=15): out_idx runs 0,1,2, and the XOR of the three refreshed shares equals the XOR of in_shares.

Source files
------------

// File: rtl/ts_sbox_pkg.sv
// rtl/ts_sbox_pkg.sv - shared state type and monomial enumeration helpers
package ts_sbox_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic int bit_count(input int v);
    int n;
    n = 0;
    for (int b = 0; b < 32; b++) n += (v >> b) & 1;
    return n;
  endfunction

  function automatic int monomial_count(input int n_in, input int max_deg);
    int cnt;
    cnt = 0;
    for (int d = 1; d <= max_deg; d++)
      for (int v = (1 << n_in) - 1; v >= 0; v--)
        if (bit_count(v) == d) cnt++;
    return cnt;
  endfunction

  // Within one degree, lexicographic order over variables (variable 0 = MSB)
  // equals descending numeric order of the select masks.
  function automatic int monomial_mask(input int n_in, input int max_deg, input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int d = 1; d <= max_deg; d++)
      for (int v = (1 << n_in) - 1; v >= 0; v--)
        if (bit_count(v) == d) begin
          if (cnt == j) res = v;
          cnt++;
        end
    return res;
  endfunction

endpackage

// File: rtl/ts_monomial_eval.sv
// rtl/ts_monomial_eval.sv - masked evaluation of all monomials of one share
module ts_monomial_eval
  import ts_sbox_pkg::*;
#(
  parameter int N_IN    = 4,
  parameter int MAX_DEG = 3,
  parameter int M       = monomial_count(N_IN, MAX_DEG)
) (
  input  logic [N_IN-1:0] share_i,
  input  logic [M-1:0]    mask_i,
  output logic [M-1:0]    sub1_o,
  output logic [M-1:0]    sub2_o
);

  logic [M-1:0] mono;

  for (genvar j = 0; j < M; j++) begin : g_mono
    localparam int SEL_INT = monomial_mask(N_IN, MAX_DEG, j);
    localparam logic [N_IN-1:0] SEL = SEL_INT[N_IN-1:0];
    // Unselected variables are forced to 1 so the AND-reduce sees only the monomial's variables.
    assign mono[j] = &(share_i | ~SEL);
  end

  assign sub1_o = mono ^ mask_i;
  assign sub2_o = mask_i;

endmodule

// File: rtl/ts_monomial_sequencer.sv
// rtl/ts_monomial_sequencer.sv - refreshes a shared S-box input and emits masked monomials one share per cycle
module ts_monomial_sequencer
  import ts_sbox_pkg::*;
#(
  parameter int N_IN     = 4,
  parameter int MAX_DEG  = 3,
  parameter int N_SHARES = 2,
  localparam int M       = monomial_count(N_IN, MAX_DEG),
  localparam int IDX_W   = ($clog2(N_SHARES) > 1) ? $clog2(N_SHARES) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_SHARES*N_IN-1:0]     in_shares,
  input  logic [(N_SHARES-1)*N_IN-1:0] rand_comp,
  input  logic [M-1:0]                 rand_fresh,
  output logic                         rand_req,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [IDX_W-1:0]             out_idx,
  output logic                         out_last,
  output logic [M-1:0]                 out_sub1,
  output logic [M-1:0]                 out_sub2
);

  state_e           state_q, state_d;
  logic [N_IN-1:0]  share_q [N_SHARES];
  logic [N_IN-1:0]  share_d [N_SHARES];
  logic [N_IN-1:0]  refreshed [N_SHARES];
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [M-1:0]     out_sub1_q, out_sub1_d;
  logic [M-1:0]     out_sub2_q, out_sub2_d;
  logic [N_IN-1:0]  comp_acc;
  logic [N_IN-1:0]  eval_share;
  logic [M-1:0]     eval_sub1, eval_sub2;
  logic             last, out_hs, accept;

  always_comb begin
    comp_acc = '0;
    for (int s = 0; s < N_SHARES - 1; s++) begin
      refreshed[s] = in_shares[s*N_IN +: N_IN] ^ rand_comp[s*N_IN +: N_IN];
      comp_acc     = comp_acc ^ rand_comp[s*N_IN +: N_IN];
    end
    refreshed[N_SHARES-1] = in_shares[(N_SHARES-1)*N_IN +: N_IN] ^ comp_acc;
  end

  assign last     = (out_idx_q == IDX_W'(N_SHARES - 1));
  assign out_hs   = out_valid_q && out_ready;
  assign in_ready = (state_q == IDLE) || (out_hs && last);
  assign accept   = in_valid && in_ready;
  assign rand_req = accept || (out_hs && !last);

  // A new input evaluates its refreshed share 0 directly; otherwise the next stored share.
  always_comb begin
    eval_share = refreshed[0];
    if (!accept) begin
      eval_share = '0;
      for (int s = 1; s < N_SHARES; s++)
        if (out_idx_q == IDX_W'(s - 1)) eval_share = share_q[s];
    end
  end

  ts_monomial_eval #(
    .N_IN   (N_IN),
    .MAX_DEG(MAX_DEG),
    .M      (M)
  ) u_eval (
    .share_i(eval_share),
    .mask_i (rand_fresh),
    .sub1_o (eval_sub1),
    .sub2_o (eval_sub2)
  );

  always_comb begin
    state_d     = state_q;
    share_d     = share_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_sub1_d  = out_sub1_q;
    out_sub2_d  = out_sub2_q;
    if (accept) begin
      state_d     = RUN;
      share_d     = refreshed;
      out_valid_d = 1'b1;
      out_idx_d   = '0;
      out_sub1_d  = eval_sub1;
      out_sub2_d  = eval_sub2;
    end else if (out_hs && !last) begin
      out_idx_d  = out_idx_q + IDX_W'(1);
      out_sub1_d = eval_sub1;
      out_sub2_d = eval_sub2;
    end else if (out_hs) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
      out_idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_sub1_q  <= '0;
      out_sub2_q  <= '0;
      for (int s = 0; s < N_SHARES; s++) share_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_sub1_q  <= out_sub1_d;
      out_sub2_q  <= out_sub2_d;
      for (int s = 0; s < N_SHARES; s++) share_q[s] <= share_d[s];
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_last  = last;
  assign out_sub1  = out_sub1_q;
  assign out_sub2  = out_sub2_q;

endmodule

// File: tb/tb_ts_monomial_sequencer.sv
// tb/tb_ts_monomial_sequencer.sv - scoreboard bench for the monomial sequencer (default and 5/2/3 configs)
module tb_ts_monomial_sequencer;

  localparam int AN = 4, AD = 3, AS = 2, AM = 14;
  localparam int BN = 5, BD = 2, BS = 3, BM = 15;

  typedef struct {
    logic [1:0]  idx;
    logic        last;
    logic [31:0] s1;
    logic [31:0] s2;
  } exp_t;

  logic clk, rst_n;

  logic               in_valid, in_ready, rand_req, out_valid, out_ready, out_last;
  logic [AS*AN-1:0]   in_shares;
  logic [(AS-1)*AN-1:0] rand_comp;
  logic [AM-1:0]      rand_fresh, out_sub1, out_sub2;
  logic [0:0]         out_idx;

  logic               b_in_valid, b_in_ready, b_rand_req, b_out_valid, b_out_ready, b_out_last;
  logic [BS*BN-1:0]   b_in_shares;
  logic [(BS-1)*BN-1:0] b_rand_comp;
  logic [BM-1:0]      b_rand_fresh, b_out_sub1, b_out_sub2;
  logic [1:0]         b_out_idx;

  int checks, errors, n_acc, n_req, req0;
  bit rf_rand, ordy_rand, ordy_fixed, stall_prev;
  logic [AM-1:0] rf_fixed;
  logic [2*AM+1:0] snap;

  logic [3:0]  pend_sh[$];
  int          pend_k[$];
  exp_t        exp_q[$];
  logic [4:0]  b_pend_sh[$];
  int          b_pend_k[$];
  exp_t        b_exp_q[$];
  logic [4:0]  bx_q[$];

  logic [3:0]  a_sh0, a_sh1;
  exp_t        ea, ma;
  exp_t        eb, mb;
  logic [4:0]  bs0, bs1, bs2, brec, bacc;
  logic [31:0] br;

  ts_monomial_sequencer #(.N_IN(AN), .MAX_DEG(AD), .N_SHARES(AS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_shares(in_shares), .rand_comp(rand_comp), .rand_fresh(rand_fresh),
    .rand_req(rand_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_idx(out_idx), .out_last(out_last), .out_sub1(out_sub1), .out_sub2(out_sub2)
  );

  ts_monomial_sequencer #(.N_IN(BN), .MAX_DEG(BD), .N_SHARES(BS)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_shares(b_in_shares), .rand_comp(b_rand_comp), .rand_fresh(b_rand_fresh),
    .rand_req(b_rand_req), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_sub1(b_out_sub1), .out_sub2(b_out_sub2)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=missing required=event", name);
  endtask

  // Monomials by walking index combinations in lexicographic order; variable i is share bit n-1-i.
  function automatic logic [31:0] ref_monos(input int n, input int maxdeg, input logic [31:0] sh);
    logic [31:0] r;
    int j, k;
    int c[8];
    bit more;
    logic p;
    r = '0;
    j = 0;
    for (int d = 1; d <= maxdeg; d++) begin
      for (int i = 0; i < d; i++) c[i] = i;
      more = 1;
      while (more) begin
        p = 1'b1;
        for (int i = 0; i < d; i++) p = p & sh[n-1-c[i]];
        r[j] = p;
        j++;
        k = d - 1;
        while (k >= 0 && c[k] == n - d + k) k--;
        if (k < 0) more = 0;
        else begin
          c[k]++;
          for (int l = k + 1; l < d; l++) c[l] = c[l-1] + 1;
        end
      end
    end
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #2;
      rand_fresh   = rf_rand ? AM'($urandom) : rf_fixed;
      b_rand_fresh = BM'($urandom);
      out_ready    = ordy_rand ? ($urandom_range(0, 3) != 0) : ordy_fixed;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pend_sh.delete();
      pend_k.delete();
    end else begin
      if (in_valid && in_ready) begin
        a_sh0 = in_shares[AN-1:0] ^ rand_comp;
        a_sh1 = in_shares[2*AN-1:AN] ^ rand_comp;
        pend_sh.push_back(a_sh0); pend_k.push_back(0);
        pend_sh.push_back(a_sh1); pend_k.push_back(1);
        n_acc++;
      end
      if (rand_req) begin
        n_req++;
        if (pend_sh.size() == 0) fail("rand_req_without_pending_share");
        else begin
          ea.idx  = 2'(pend_k[0]);
          ea.last = (pend_k[0] == AS - 1);
          ea.s1   = ref_monos(AN, AD, 32'(pend_sh[0])) ^ 32'(rand_fresh);
          ea.s2   = 32'(rand_fresh);
          void'(pend_sh.pop_front());
          void'(pend_k.pop_front());
          exp_q.push_back(ea);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) chk("hold_stable", {out_valid, out_idx, out_sub1, out_sub2}, snap);
      stall_prev = 0;
      if (out_valid && !out_ready) begin
        chk("stall_rand_req", rand_req, 0);
        chk("stall_in_ready", in_ready, 0);
        snap = {out_valid, out_idx, out_sub1, out_sub2};
        stall_prev = 1;
      end else if (out_valid) begin
        if (exp_q.size() == 0) fail("unexpected_beat");
        else begin
          ma = exp_q.pop_front();
          chk("out_idx", out_idx, ma.idx);
          chk("out_last", out_last, ma.last);
          chk("out_sub1", out_sub1, ma.s1);
          chk("out_sub2", out_sub2, ma.s2);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_pend_sh.delete();
      b_pend_k.delete();
      bx_q.delete();
    end else begin
      if (b_in_valid && b_in_ready) begin
        bs0 = b_in_shares[4:0] ^ b_rand_comp[4:0];
        bs1 = b_in_shares[9:5] ^ b_rand_comp[9:5];
        bs2 = b_in_shares[14:10] ^ b_rand_comp[4:0] ^ b_rand_comp[9:5];
        b_pend_sh.push_back(bs0); b_pend_k.push_back(0);
        b_pend_sh.push_back(bs1); b_pend_k.push_back(1);
        b_pend_sh.push_back(bs2); b_pend_k.push_back(2);
        bx_q.push_back(b_in_shares[4:0] ^ b_in_shares[9:5] ^ b_in_shares[14:10]);
      end
      if (b_rand_req) begin
        if (b_pend_sh.size() == 0) fail("b_rand_req_without_pending_share");
        else begin
          eb.idx  = 2'(b_pend_k[0]);
          eb.last = (b_pend_k[0] == BS - 1);
          eb.s1   = ref_monos(BN, BD, 32'(b_pend_sh[0])) ^ 32'(b_rand_fresh);
          eb.s2   = 32'(b_rand_fresh);
          void'(b_pend_sh.pop_front());
          void'(b_pend_k.pop_front());
          b_exp_q.push_back(eb);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      b_exp_q.delete();
      bacc = '0;
    end else if (b_out_valid && b_out_ready) begin
      if (b_exp_q.size() == 0) fail("b_unexpected_beat");
      else begin
        mb = b_exp_q.pop_front();
        chk("b_out_idx", b_out_idx, mb.idx);
        chk("b_out_last", b_out_last, mb.last);
        chk("b_out_sub1", b_out_sub1, mb.s1);
        chk("b_out_sub2", b_out_sub2, mb.s2);
        // Degree-1 monomials recover the refreshed share itself.
        br = 32'(b_out_sub1 ^ b_out_sub2);
        for (int j = 0; j < BN; j++) brec[BN-1-j] = br[j];
        bacc = bacc ^ brec;
        if (b_out_last) begin
          if (bx_q.size() == 0) fail("b_share_xor_missing");
          else chk("b_share_xor", bacc, bx_q.pop_front());
          bacc = '0;
        end
      end
    end
  end

  task automatic send_a(input logic [7:0] sh, input logic [3:0] comp);
    int t;
    in_shares = sh;
    rand_comp = comp;
    in_valid  = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!in_ready && t < 200);
    if (!in_ready) fail("accept_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [14:0] sh, input logic [9:0] comp);
    int t;
    b_in_shares = sh;
    b_rand_comp = comp;
    b_in_valid  = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!b_in_ready && t < 200);
    if (!b_in_ready) fail("b_accept_timeout");
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin @(negedge clk); t++; end
    while ((out_valid || b_out_valid || exp_q.size() != 0 || b_exp_q.size() != 0) && t < 200);
    if (t >= 200) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0; n_acc = 0; n_req = 0;
    rf_rand = 0; rf_fixed = '0; ordy_rand = 0; ordy_fixed = 1;
    rst_n = 0;
    in_valid = 0; in_shares = '0; rand_comp = '0; rand_fresh = '0; out_ready = 1;
    b_in_valid = 0; b_in_shares = '0; b_rand_comp = '0; b_rand_fresh = '0; b_out_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_sub1", out_sub1, 0);
    chk("rst_out_sub2", out_sub2, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rand_req", rand_req, 0);
    chk("rst_b_out_valid", b_out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1;

    req0 = n_req;
    send_a(8'h0B, 4'h0);
    @(negedge clk);
    chk("t1_idx0", out_idx, 0);
    chk("t1_sub1_s0", out_sub1, 14'h126D);
    chk("t1_sub2_s0", out_sub2, 14'h0000);
    @(negedge clk);
    chk("t1_idx1", out_idx, 1);
    chk("t1_last", out_last, 1);
    chk("t1_sub1_s1", out_sub1, 14'h0000);
    @(posedge clk); #1;
    wait_idle();
    chk("t1_rand_req_count", n_req - req0, 2);

    rf_fixed = 14'h3FFF;
    req0 = n_req;
    send_a(8'h0B, 4'h0);
    @(negedge clk);
    chk("t2_sub1_s0", out_sub1, 14'h2D92);
    chk("t2_sub2_s0", out_sub2, 14'h3FFF);
    @(negedge clk);
    chk("t2_sub1_s1", out_sub1, 14'h3FFF);
    @(posedge clk); #1;
    wait_idle();
    chk("t2_rand_req_count", n_req - req0, 2);

    rf_fixed = '0;
    send_a(8'h0F, 4'hF);
    @(negedge clk);
    chk("t3_sub1_s0", out_sub1, 14'h0000);
    @(negedge clk);
    chk("t3_sub1_s1", out_sub1, 14'h3FFF);
    @(posedge clk); #1;
    wait_idle();

    rf_rand = 1;
    ordy_fixed = 0;
    send_a(8'($urandom), 4'($urandom));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_idx, 0);
      chk("bp_rand_req", rand_req, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    ordy_fixed = 1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_idx", out_idx, 1);
    @(posedge clk); #1;
    wait_idle();

    in_shares = 8'($urandom);
    rand_comp = 4'($urandom);
    in_valid  = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 0) chk("b2b_first_ready", in_ready, 1);
      else begin
        chk("b2b_valid", out_valid, 1);
        chk("b2b_idx", out_idx, (c - 1) % 2);
        chk("b2b_in_ready", in_ready, (c - 1) % 2 == 1);
      end
      @(posedge clk); #1;
      in_shares = 8'($urandom);
      rand_comp = 4'($urandom);
    end
    in_valid = 1'b0;
    wait_idle();

    ordy_rand = 1;
    for (int i = 0; i < 40; i++) begin
      send_a(8'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    ordy_rand = 0;
    ordy_fixed = 1;
    wait_idle();

    for (int i = 0; i < 12; i++) begin
      send_b(15'($urandom), 10'($urandom));
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    wait_idle();

    send_a(8'($urandom), 4'($urandom));
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_pre_idx", out_idx, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_out_idx", out_idx, 0);
    chk("rstmid_out_last", out_last, 0);
    chk("rstmid_out_sub1", out_sub1, 0);
    chk("rstmid_out_sub2", out_sub2, 0);
    chk("rstmid_in_ready", in_ready, 1);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    send_a(8'($urandom), 4'($urandom));
    @(negedge clk);
    chk("post_rst_idx", out_idx, 0);
    @(posedge clk); #1;
    wait_idle();

    chk("rand_req_total", n_req, 2 * n_acc);
    chk("scoreboard_drained", exp_q.size() + pend_sh.size() + b_exp_q.size() + bx_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
